if_fetch_stage: RTL and testbench

//  Instruction-fetch initiator: owns the PC, drives the instruction-memory address and captures
//  the returned word into the IF/ID pipeline register. Sits between the hazard/branch logic
//  (freeze, branch redirect) and the ID stage.

---
 rtl/ca_pkg.sv | 20 ++
 rtl/if_fetch_stage_pc_reg.sv | 19 +
 rtl/if_fetch_stage.sv | 46 ++++
 tb/tb_if_fetch_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/ca_pkg.sv
// ca_pkg: pipeline-wide constants and instruction field layout shared by the IF and ID stages.
package ca_pkg;
  localparam int PC_W = 32;
  localparam logic [31:0] NOP_INST = 32'h0;
  localparam int OP_W = 6;
  localparam int RS_W = 5;
  localparam int RT_W = 5;
  localparam int RD_W = 5;
  localparam int REST_W = 11;
  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [RS_W-1:0] rs;
    logic [RT_W-1:0] rt;
    logic [RD_W-1:0] rd;
    logic [REST_W-1:0] rest;
  } inst_t;
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
    return {a[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// pc_reg: program counter with branch load, freeze-aware enable and sync active-low reset.
module pc_reg import ca_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'd0,
  parameter logic [PC_W-1:0] PC_STEP = 32'd4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic [PC_W-1:0] load_addr,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_next
);
  assign pc_next = pc + PC_STEP;
  always_ff @(posedge clk)
    if (!rst_n) pc <= RESET_PC;
    else if (load) pc <= load_addr;
    else if (en) pc <= pc_next;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the PC, drives instruction memory and captures the fetched word into IF/ID.
module if_fetch_stage import ca_pkg::*; #(
  parameter logic [PC_W-1:0] RESET_PC = 32'd0,
  parameter logic [PC_W-1:0] PC_STEP = 32'd4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_addr,
  output logic [PC_W-1:0]  inst_addr,
  input  logic [31:0]      inst_in,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [31:0]      ifid_inst,
  output logic             ifid_valid,
  output logic [CNT_W-1:0] fetch_count
);
  logic [PC_W-1:0] pc_next;
  pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .load(branch_taken),
    .en(!freeze),
    .load_addr(align_word(branch_addr)),
    .pc(inst_addr),
    .pc_next(pc_next)
  );
  // a redirect flushes IF/ID even while frozen; the counter only tracks accepted fetches
  always_ff @(posedge clk)
    if (!rst_n) begin
      ifid_pc <= '0;
      ifid_inst <= NOP_INST;
      ifid_valid <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      ifid_pc <= '0;
      ifid_inst <= NOP_INST;
      ifid_valid <= 1'b0;
    end else if (!freeze) begin
      ifid_pc <= pc_next;
      ifid_inst <= inst_in;
      ifid_valid <= 1'b1;
      fetch_count <= (fetch_count == '1) ? fetch_count : fetch_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scoreboard bench for if_fetch_stage (plus a CNT_W=2 copy for saturation).
module tb_if_fetch_stage;
  logic clk = 0, rst_n = 0, freeze = 0, branch_taken = 0;
  logic [31:0] branch_addr = 0;
  logic [31:0] inst_addr, inst_in, ifid_pc, ifid_inst;
  logic [31:0] inst_addr2, inst_in2, ifid_pc2, ifid_inst2;
  logic ifid_valid, ifid_valid2;
  logic [15:0] fetch_count;
  logic [1:0] fetch_count2;
  int total = 0, bad = 0;

  typedef struct {
    logic [31:0] addr, ipc, inst;
    logic valid;
    logic [15:0] cnt;
    logic [1:0] cnt2;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_pc = 0, m_ipc = 0, m_inst = 0;
  logic m_valid = 0;
  logic [15:0] m_cnt = 0;
  logic [1:0] m_cnt2 = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a == 32'd0 ? 32'h0022_0000 : a == 32'd4 ? 32'h0064_0000 : a == 32'd8 ? 32'h00A6_0000 : 32'h0;
  endfunction
  assign inst_in = mem(inst_addr);
  assign inst_in2 = mem(inst_addr2);

  if_fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .inst_addr(inst_addr), .inst_in(inst_in), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
    .ifid_valid(ifid_valid), .fetch_count(fetch_count));
  if_fetch_stage #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .freeze(freeze), .branch_taken(branch_taken), .branch_addr(branch_addr),
    .inst_addr(inst_addr2), .inst_in(inst_in2), .ifid_pc(ifid_pc2), .ifid_inst(ifid_inst2),
    .ifid_valid(ifid_valid2), .fetch_count(fetch_count2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic fz, input logic br, input logic [31:0] ba);
    exp_t e;
    rst_n = r; freeze = fz; branch_taken = br; branch_addr = ba;
    if (!r) begin
      m_pc = 0; m_ipc = 0; m_inst = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else if (br) begin
      m_pc = {ba[31:2], 2'b00}; m_ipc = 0; m_inst = 0; m_valid = 0;
    end else if (!fz) begin
      m_inst = mem(m_pc); m_pc = m_pc + 32'd4; m_ipc = m_pc; m_valid = 1;
      if (m_cnt != 16'hFFFF) m_cnt++;
      if (m_cnt2 != 2'b11) m_cnt2++;
    end
    e = '{m_pc, m_ipc, m_inst, m_valid, m_cnt, m_cnt2};
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("inst_addr", inst_addr, e.addr);
    check("ifid_pc", ifid_pc, e.ipc);
    check("ifid_inst", ifid_inst, e.inst);
    check("ifid_valid", 32'(ifid_valid), 32'(e.valid));
    check("fetch_count", 32'(fetch_count), 32'(e.cnt));
    check("fetch_count2", 32'(fetch_count2), 32'(e.cnt2));
    check("addr2", inst_addr2, e.addr);
  endtask

  initial begin
    step(0, 0, 0, 0);
    check("rst_addr", inst_addr, 32'd0);
    check("rst_valid", 32'(ifid_valid), 32'd0);
    repeat (3) step(1, 0, 0, 0);
    check("t1_addr", inst_addr, 32'd12);
    check("t1_inst", ifid_inst, 32'h00A6_0000);
    check("t1_pc", ifid_pc, 32'd12);
    check("t1_cnt", 32'(fetch_count), 32'd3);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    check("t2_addr", inst_addr, 32'd4);
    check("t2_inst", ifid_inst, 32'h0022_0000);
    check("t2_cnt", 32'(fetch_count), 32'd1);
    step(1, 0, 0, 0);
    check("t2_rel", ifid_inst, 32'h0064_0000);
    step(1, 1, 1, 32'd8);
    check("t3_addr", inst_addr, 32'd8);
    check("t3_valid", 32'(ifid_valid), 32'd0);
    check("t3_inst", ifid_inst, 32'd0);
    step(1, 0, 0, 0);
    check("t3_tgt", ifid_inst, 32'h00A6_0000);
    step(1, 0, 1, 32'h0000_0007);
    check("t4_addr", inst_addr, 32'd4);
    step(1, 0, 1, 32'd0);
    step(1, 0, 1, 32'd8);
    check("b2b_valid", 32'(ifid_valid), 32'd0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'd8);
    check("t5_addr", inst_addr, 32'd0);
    check("t5_inst", ifid_inst, 32'd0);
    check("t5_cnt", 32'(fetch_count), 32'd0);
    step(1, 0, 1, 32'hFFFF_FFFC);
    check("t6_br", inst_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check("t6_wrap_addr", inst_addr, 32'd0);
    check("t6_wrap_pc", ifid_pc, 32'd0);
    repeat (4) step(1, 0, 0, 0);
    check("t6_sat2", 32'(fetch_count2), 32'd3);
    check("t6_cnt16", 32'(fetch_count), 32'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
